// File: rtl/write_module_if.sv
// Store bus between control/datapath (master) and write_module (slave).
// elem_mask exists only when WRITE_MODULE_MASK_EN is defined.
interface write_module_if #(
  parameter int I = 20,
  parameter int L = 32,
  parameter int A = 6
);
  logic                  start;
  logic                  op_type;
  logic [A-1:0]          base_address;
  logic [L-1:0]          scalar_data;
  logic [I-1:0][L-1:0]   vector_data;
`ifdef WRITE_MODULE_MASK_EN
  logic [I-1:0]          elem_mask;
`endif
  logic [A-1:0]          write_address;
  logic [L-1:0]          write_data;
  logic                  write_enable;
  logic                  busy;
  logic                  finished;

  modport master (
    output start, op_type, base_address, scalar_data, vector_data,
`ifdef WRITE_MODULE_MASK_EN
    output elem_mask,
`endif
    input  write_address, write_data, write_enable, busy, finished
  );

  modport slave (
    input  start, op_type, base_address, scalar_data, vector_data,
`ifdef WRITE_MODULE_MASK_EN
    input  elem_mask,
`endif
    output write_address, write_data, write_enable, busy, finished
  );
endinterface

// File: rtl/write_module.sv
// Streams a scalar or I-element vector into data memory, one word per cycle from base upward;
// start ignored while busy, finished pulses one cycle after the last write. Option: WRITE_MODULE_MASK_EN.
module write_module #(
  parameter int I = 20,
  parameter int L = 32,
  parameter int A = 6
) (
  input logic           clk,
  input logic           rst,
  write_module_if.slave bus
);
  localparam int            IW       = (I > 1) ? $clog2(I) : 1;
  localparam logic [A-1:0]  VEC_LAST = A'(I - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [A-1:0]        idx;
  logic [A-1:0]        base_q;
  logic                op_q;
  logic [I-1:0][L-1:0] buf_q;
  logic [IW-1:0]       sel;
  logic                last_elem;
  logic                elem_en;

`ifdef WRITE_MODULE_MASK_EN
  logic [I-1:0]        mask_q;
  assign elem_en = mask_q[sel];
`else
  assign elem_en = 1'b1;
`endif

  assign sel       = idx[IW-1:0];
  assign last_elem = op_q ? (idx == VEC_LAST) : (idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      base_q <= '0;
      op_q   <= 1'b0;
      buf_q  <= '0;
`ifdef WRITE_MODULE_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q <= bus.base_address;
            op_q   <= bus.op_type;
            idx    <= '0;
            // A scalar only refreshes slot 0; other slots are never read for op_q=0.
            if (bus.op_type)
              buf_q <= bus.vector_data;
            else
              buf_q[0] <= bus.scalar_data;
`ifdef WRITE_MODULE_MASK_EN
            mask_q <= bus.elem_mask;
`endif
            state  <= WRITE;
          end
        end
        WRITE: begin
          idx <= idx + 1'b1;
          if (last_elem)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.write_enable  = (state == WRITE) & elem_en;
  assign bus.write_address = (state == WRITE) ? (base_q + idx) : '0;
  assign bus.write_data    = (state == WRITE) ? buf_q[sel] : '0;
  assign bus.busy          = (state != IDLE);
  assign bus.finished      = (state == DONE);
endmodule

// File: tb/tb_write_module.sv
// Directed bench for write_module: vector, scalar, wrap, start-while-busy, reset mid-store, mask.
module tb_write_module;
  localparam int I = 20;
  localparam int L = 32;
  localparam int A = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  write_module_if #(.I(I), .L(L), .A(A)) bus ();

  write_module #(.I(I), .L(L), .A(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_we"},   32'(bus.write_enable),  32'd0);
    chk({tag, "_addr"}, 32'(bus.write_address), 32'd0);
    chk({tag, "_data"}, bus.write_data,         32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),          32'd0);
    chk({tag, "_fin"},  32'(bus.finished),      32'd0);
  endtask

  task automatic chk_write(input string tag, input logic we, input logic [A-1:0] addr,
                           input logic [L-1:0] data);
    chk({tag, "_we"},   32'(bus.write_enable),  32'(we));
    chk({tag, "_addr"}, 32'(bus.write_address), 32'(addr));
    chk({tag, "_data"}, bus.write_data,         data);
    chk({tag, "_busy"}, 32'(bus.busy),          32'd1);
    chk({tag, "_fin"},  32'(bus.finished),      32'd0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_we"},   32'(bus.write_enable),  32'd0);
    chk({tag, "_addr"}, 32'(bus.write_address), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),          32'd1);
    chk({tag, "_fin"},  32'(bus.finished),      32'd1);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.op_type      = 1'b0;
    bus.base_address = '0;
    bus.scalar_data  = '0;
    bus.vector_data  = '0;
`ifdef WRITE_MODULE_MASK_EN
    bus.elem_mask    = '1;
`endif

    // reset state
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // 1: vector store base 4, data A0..B3
    bus.op_type      = 1'b1;
    bus.base_address = 6'd4;
    for (int j = 0; j < I; j++) bus.vector_data[j] = 32'hA0 + 32'(j);
    bus.start = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.vector_data = '0;
    for (int j = 0; j < I; j++) begin
      chk_write($sformatf("t1_e%0d", j), 1'b1, 6'(4 + j), 32'hA0 + 32'(j));
      tick();
    end
    chk_done("t1_done");
    tick();
    chk_idle("t1_idle");

    // 2: scalar store base 9
    bus.op_type      = 1'b0;
    bus.base_address = 6'd9;
    bus.scalar_data  = 32'hDEAD_BEEF;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_write("t2_e0", 1'b1, 6'd9, 32'hDEAD_BEEF);
    tick();
    chk_done("t2_done");
    tick();
    chk_idle("t2_idle");

    // 3: vector wrapping past the top of the address space
    bus.op_type      = 1'b1;
    bus.base_address = 6'd60;
    for (int j = 0; j < I; j++) bus.vector_data[j] = 32'h1000 + 32'(j);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < I; j++) begin
      chk_write($sformatf("t3_e%0d", j), 1'b1, 6'((60 + j) % 64), 32'h1000 + 32'(j));
      tick();
    end
    chk_done("t3_done");
    tick();
    chk_idle("t3_idle");

    // 4: start held high through WRITE/DONE; new base 30 only taken after IDLE
    bus.op_type      = 1'b0;
    bus.base_address = 6'd12;
    bus.scalar_data  = 32'h1111_2222;
    bus.start        = 1'b1;
    tick();
    bus.base_address = 6'd30;
    bus.scalar_data  = 32'h3333_4444;
    chk_write("t4_first", 1'b1, 6'd12, 32'h1111_2222);
    tick();
    chk_done("t4_done1");
    tick();
    chk_idle("t4_gap");
    tick();
    bus.start = 1'b0;
    chk_write("t4_second", 1'b1, 6'd30, 32'h3333_4444);
    tick();
    chk_done("t4_done2");
    tick();
    chk_idle("t4_idle");

    // 5: reset at element 7 of a vector store
    bus.op_type      = 1'b1;
    bus.base_address = 6'd0;
    for (int j = 0; j < I; j++) bus.vector_data[j] = 32'hC0 + 32'(j);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 7; j++) tick();
    chk_write("t5_e7", 1'b1, 6'd7, 32'hC7);
    rst = 1'b1;
    tick();
    chk_idle("t5_rst1");
    tick();
    chk_idle("t5_rst2");
    rst = 1'b0;
    tick();
    chk_idle("t5_after");
    // rst and start on the same edge: rst wins
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    chk_idle("t5_rst_start");
    rst              = 1'b0;
    bus.op_type      = 1'b0;
    bus.base_address = 6'd5;
    bus.scalar_data  = 32'h55;
    tick();
    bus.start = 1'b0;
    chk_write("t5_restart", 1'b1, 6'd5, 32'h55);
    tick();
    chk_done("t5_done");
    tick();
    chk_idle("t5_idle");

`ifdef WRITE_MODULE_MASK_EN
    // 6: masked vector, only elements 0 and 2 strobe
    bus.op_type      = 1'b1;
    bus.base_address = 6'd10;
    bus.elem_mask    = 20'h00005;
    for (int j = 0; j < I; j++) bus.vector_data[j] = 32'hE0 + 32'(j);
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.elem_mask = '1;
    for (int j = 0; j < I; j++) begin
      chk_write($sformatf("t6_e%0d", j), (j == 0 || j == 2), 6'(10 + j), 32'hE0 + 32'(j));
      tick();
    end
    chk_done("t6_done");
    tick();
    chk_idle("t6_idle");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
